// File: rtl/states_pkg.sv
// Shared state encodings for the core sequencer, register files and LSUs.
package states_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_t;

    localparam logic [2:0] FETCHED = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_t;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT    = 2'b01;
    localparam logic [1:0] ERR_DIVERGENCE = 2'b10;

endpackage

// File: rtl/lane_status.sv
// Reduces per-lane LSU state and next PC over the active lanes into
// a memory-busy flag and a PC-divergence flag.
module lane_status
    import states_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4
) (
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic [8*THREADS_PER_BLOCK-1:0]       next_pc,
    output logic                                 mem_busy,
    output logic                                 diverged
);

    localparam int CNT_W = $clog2(THREADS_PER_BLOCK) + 1;

    logic [CNT_W-1:0] active_cnt;

    always_comb begin
        // Lane 0 is always active, even when the dispatcher reports zero lanes.
        active_cnt = (thread_count == '0) ? CNT_W'(1) : thread_count;
        mem_busy   = 1'b0;
        diverged   = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (CNT_W'(i) < active_cnt) begin
                if ((lsu_state[2*i +: 2] == LSU_REQUESTING) ||
                    (lsu_state[2*i +: 2] == LSU_WAITING))
                    mem_busy = 1'b1;
                if (next_pc[8*i +: 8] != next_pc[7:0])
                    diverged = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Per-core control FSM: steps each instruction through fetch, decode, memory
// wait, execute and PC update, and flags LSU timeouts and lane divergence.
module core_sequencer
    import states_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int WAIT_TIMEOUT      = 255
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]   thread_count,
    input  logic                                 decoded_mem_read_enable,
    input  logic                                 decoded_mem_write_enable,
    input  logic                                 decoded_ret,
    input  logic [2:0]                           fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
    input  logic [8*THREADS_PER_BLOCK-1:0]       next_pc,
    output logic [2:0]                           core_state,
    output logic [7:0]                           current_pc,
    output logic                                 done,
    output logic                                 error,
    output logic [1:0]                           error_code
);

    localparam int WAIT_CNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_TIMEOUT - 1);

    core_state_t            state, state_nxt;
    logic [7:0]             pc_nxt;
    logic                   done_nxt, error_nxt;
    logic [1:0]             code_nxt;
    logic [WAIT_CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic                   mem_busy, diverged;

    // WAIT exit is decided from LSU status alone; the decoder's memory flags
    // are part of the shared core interface but do not steer this FSM.
    logic unused_mem_flags;
    assign unused_mem_flags = decoded_mem_read_enable ^ decoded_mem_write_enable;

    lane_status #(
        .THREADS_PER_BLOCK (THREADS_PER_BLOCK)
    ) u_lane_status (
        .thread_count (thread_count),
        .lsu_state    (lsu_state),
        .next_pc      (next_pc),
        .mem_busy     (mem_busy),
        .diverged     (diverged)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            current_pc <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            error_code <= ERR_NONE;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            current_pc <= pc_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            error_code <= code_nxt;
            wait_cnt   <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = current_pc;
        done_nxt     = done;
        error_nxt    = error;
        code_nxt     = error_code;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    pc_nxt    = '0;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    code_nxt  = ERR_NONE;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (fetcher_state == FETCHED)
                    state_nxt = DECODE;
            end
            DECODE:  state_nxt = REQUEST;
            REQUEST: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt + 1'b1;
                if (!mem_busy) begin
                    state_nxt = EXECUTE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                end
            end
            EXECUTE: state_nxt = UPDATE;
            UPDATE: begin
                if (decoded_ret) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (diverged) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    error_nxt = 1'b1;
                    code_nxt  = ERR_DIVERGENCE;
                end else begin
                    pc_nxt    = next_pc[7:0];
                    state_nxt = FETCH;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign core_state = state;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: walks the FSM through normal, memory
// wait, inactive-lane, wrap, divergence, timeout and reset scenarios.
module tb_core_sequencer;
    import states_pkg::*;

    localparam int T  = 4;
    localparam int WT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  thread_count;
    logic        rd_en, wr_en, ret;
    logic [2:0]  fetcher_state;
    logic [7:0]  lsu_state;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        done, error;
    logic [1:0]  error_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    core_sequencer #(
        .THREADS_PER_BLOCK (T),
        .WAIT_TIMEOUT      (WT)
    ) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .start                    (start),
        .thread_count             (thread_count),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .decoded_ret              (ret),
        .fetcher_state            (fetcher_state),
        .lsu_state                (lsu_state),
        .next_pc                  (next_pc),
        .core_state               (core_state),
        .current_pc               (current_pc),
        .done                     (done),
        .error                    (error),
        .error_code               (error_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_expect(input string tag, input logic [2:0] exp_state);
        @(negedge clk);
        chk(tag, 32'(core_state), 32'(exp_state));
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] st, input logic [7:0] pc,
                            input logic dn, input logic er, input logic [1:0] code);
        chk({tag, "_state"}, 32'(core_state), 32'(st));
        chk({tag, "_pc"},    32'(current_pc), 32'(pc));
        chk({tag, "_done"},  32'(done),       32'(dn));
        chk({tag, "_error"}, 32'(error),      32'(er));
        chk({tag, "_code"},  32'(error_code), 32'(code));
    endtask

    // Entered right after observing FETCH; leaves having observed REQUEST.
    task automatic fetch_to_request(input string tag);
        fetcher_state = FETCHED;
        step_expect({tag, "_decode"}, 3'd2);
        fetcher_state = 3'b000;
        step_expect({tag, "_request"}, 3'd3);
    endtask

    // One non-memory instruction from FETCH back to FETCH with a new PC.
    task automatic run_instr(input string tag, input logic [31:0] npc, input logic [7:0] exp_pc);
        next_pc = npc;
        fetch_to_request(tag);
        step_expect({tag, "_wait"}, 3'd4);
        step_expect({tag, "_exec"}, 3'd5);
        step_expect({tag, "_update"}, 3'd6);
        step_expect({tag, "_fetch"}, 3'd1);
        chk({tag, "_pc"}, 32'(current_pc), 32'(exp_pc));
        chk({tag, "_err"}, 32'(error), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        start   = 1'b0;
        reset_n = 1'b0;
        #1;
        chk_outs(tag, 3'd0, 8'h00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n       = 1'b1;
        start         = 1'b0;
        thread_count  = 3'd4;
        rd_en         = 1'b0;
        wr_en         = 1'b0;
        ret           = 1'b0;
        fetcher_state = 3'b000;
        lsu_state     = 8'h00;
        next_pc       = 32'h01010101;

        #3 reset_n = 1'b0;
        #1 chk_outs("por", 3'd0, 8'h00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step_expect("idle_hold", 3'd0);

        // Basic instruction: 1,1,1,2,3,4,5,6,1
        start = 1'b1;
        step_expect("basic_f1", 3'd1);
        start = 1'b0;
        chk("basic_pc0", 32'(current_pc), 32'h00);
        step_expect("basic_f2", 3'd1);
        step_expect("basic_f3", 3'd1);
        fetch_to_request("basic");
        step_expect("basic_wait", 3'd4);
        step_expect("basic_exec", 3'd5);
        step_expect("basic_update", 3'd6);
        step_expect("basic_fetch", 3'd1);
        chk("basic_pc", 32'(current_pc), 32'h01);

        // Memory load: LSUs busy for 5 sampled WAIT cycles -> 6 WAIT cycles
        rd_en = 1'b1;
        fetch_to_request("ldr");
        lsu_state = 8'hAA;
        for (int k = 1; k <= 6; k++) begin
            step_expect("ldr_wait", 3'd4);
            if (k == 6) lsu_state = 8'hFF;
        end
        step_expect("ldr_exec", 3'd5);
        rd_en     = 1'b0;
        lsu_state = 8'h00;
        next_pc   = 32'h02020202;
        step_expect("ldr_update", 3'd6);
        step_expect("ldr_fetch", 3'd1);
        chk("ldr_pc", 32'(current_pc), 32'h02);

        // Inactive lanes busy and divergent are ignored
        thread_count = 3'd2;
        next_pc      = 32'h77770303;
        fetch_to_request("inact");
        lsu_state = 8'h8F;
        step_expect("inact_wait", 3'd4);
        step_expect("inact_exit", 3'd5);
        lsu_state = 8'h00;
        step_expect("inact_update", 3'd6);
        step_expect("inact_fetch", 3'd1);
        chk("inact_pc", 32'(current_pc), 32'h03);
        chk("inact_err", 32'(error), 32'd0);

        // PC wraps modulo 256 without a flag
        thread_count = 3'd4;
        run_instr("pc_ff", 32'hFFFFFFFF, 8'hFF);
        run_instr("pc_wrap", 32'h00000000, 8'h00);

        // Divergence in lane 2: ignored with two lanes, fatal with four
        thread_count = 3'd2;
        run_instr("div2", 32'h05090505, 8'h05);
        thread_count = 3'd4;
        next_pc      = 32'h05090505;
        fetch_to_request("div4");
        step_expect("div4_wait", 3'd4);
        step_expect("div4_exec", 3'd5);
        step_expect("div4_update", 3'd6);
        step_expect("div4_done", 3'd7);
        chk_outs("div4", 3'd7, 8'h05, 1'b1, 1'b1, 2'b10);

        // DONE holds and ignores start
        start = 1'b1;
        repeat (3) step_expect("done_hold", 3'd7);
        start = 1'b0;
        chk_outs("done_held", 3'd7, 8'h05, 1'b1, 1'b1, 2'b10);

        // Timeout with thread_count=0 (lane 0 still active) stuck REQUESTING
        do_reset("rst1");
        thread_count = 3'd0;
        next_pc      = 32'h00000000;
        start        = 1'b1;
        step_expect("to_fetch", 3'd1);
        start = 1'b0;
        fetch_to_request("to");
        lsu_state = 8'h01;
        for (int k = 1; k <= WT; k++) step_expect("to_wait", 3'd4);
        step_expect("to_done", 3'd7);
        chk_outs("to", 3'd7, 8'h00, 1'b1, 1'b1, 2'b01);

        // Asynchronous reset mid-WAIT
        do_reset("rst2");
        lsu_state    = 8'h00;
        thread_count = 3'd4;
        start        = 1'b1;
        step_expect("ar_fetch", 3'd1);
        start = 1'b0;
        rd_en = 1'b1;
        fetch_to_request("ar");
        lsu_state = 8'hAA;
        step_expect("ar_wait1", 3'd4);
        step_expect("ar_wait2", 3'd4);
        #2 reset_n = 1'b0;
        #1 chk_outs("ar_async", 3'd0, 8'h00, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        reset_n   = 1'b1;
        lsu_state = 8'h00;
        rd_en     = 1'b0;
        step_expect("ar_idle", 3'd0);

        // Return on the second instruction keeps the PC
        start = 1'b1;
        step_expect("ret_fetch", 3'd1);
        start = 1'b0;
        run_instr("ret_i1", 32'h10101010, 8'h10);
        next_pc = 32'h20202020;
        ret     = 1'b1;
        fetch_to_request("ret_i2");
        step_expect("ret_wait", 3'd4);
        step_expect("ret_exec", 3'd5);
        step_expect("ret_update", 3'd6);
        step_expect("ret_done", 3'd7);
        chk_outs("ret", 3'd7, 8'h10, 1'b1, 1'b0, 2'b00);
        ret = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
